// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR write-back arbiter: register index, word, parked entry.
package gpr_wb_arbiter_pkg;

    localparam int unsigned RegIdxW   = 5;
    localparam int unsigned WordWidth = 32;

    typedef logic [RegIdxW-1:0]   reg_index_t;
    typedef logic [WordWidth-1:0] word_t;

    typedef struct packed {
        logic       valid;
        reg_index_t dest;
        word_t      data;
    } wb_entry_t;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bus bundle between the result producers / decode and the write-back arbiter.
// master: pipeline side (drives results and operand indices); slave: arbiter side.
interface gpr_wb_arbiter_if
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_TESTPORTS = 3
);

    logic                                alu_valid;
    reg_index_t                          alu_dest;
    logic       [DATA_WIDTH-1:0]         alu_data;
    logic                                mem_valid;
    reg_index_t                          mem_dest;
    logic       [DATA_WIDTH-1:0]         mem_data;
    logic                                wb_en;
    reg_index_t                          wb_dest;
    logic       [DATA_WIDTH-1:0]         wb_data;
    logic                                hold;
    reg_index_t [NUM_TESTPORTS-1:0]      test_idx;
    logic       [NUM_TESTPORTS-1:0]      test_hit;
    logic                                overflow;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output test_idx,
        input  wb_en, wb_dest, wb_data, hold, test_hit, overflow
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  test_idx,
        output wb_en, wb_dest, wb_data, hold, test_hit, overflow
    );

endinterface

// File: rtl/gpr_wb_fifo.sv
// In-order circular buffer for parked ALU results. A push is accepted when not
// full or when the head pops in the same cycle. entry_live_o marks entries that
// remain parked after this cycle (the popping head is excluded).
module gpr_wb_fifo
    import gpr_wb_arbiter_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned BUF_DEPTH  = 2,
    localparam int unsigned CountW     = count_width(BUF_DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             push_i,
    input  reg_index_t                       push_dest_i,
    input  logic       [DATA_WIDTH-1:0]      push_data_i,
    input  logic                             pop_i,
    output reg_index_t                       head_dest_o,
    output logic       [DATA_WIDTH-1:0]      head_data_o,
    output logic       [CountW-1:0]          count_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic       [BUF_DEPTH-1:0]       entry_live_o,
    output reg_index_t [BUF_DEPTH-1:0]       entry_dest_o
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);

    logic       [BUF_DEPTH-1:0]  valid_q, valid_d;
    reg_index_t                  dest_q [BUF_DEPTH];
    logic       [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
    logic       [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic       [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic       [CountW-1:0]     count_q, count_d;
    logic                        do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CountW'(BUF_DEPTH));
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign count_o     = count_q;
    assign head_dest_o = dest_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // Next pointers, occupancy and valid bits; a push into the slot being popped wins.
    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = next_ptr(rd_ptr_q);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = next_ptr(wr_ptr_q);
        end
        count_d = count_q + CountW'(do_push) - CountW'(do_pop);
    end

    // Per-entry views for the hazard comparators.
    always_comb begin
        entry_live_o = valid_q;
        if (do_pop) begin
            entry_live_o[rd_ptr_q] = 1'b0;
        end
        for (int e = 0; e < BUF_DEPTH; e++) begin
            entry_dest_o[e] = dest_q[e];
        end
    end

    // Buffer state; reset discards every parked entry at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int e = 0; e < BUF_DEPTH; e++) begin
                dest_q[e] <= '0;
                data_q[e] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                dest_q[wr_ptr_q] <= push_dest_i;
                data_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Single GPR write-port arbiter: loads always win, ALU results park in an
// in-order FIFO and drain on idle port cycles. Reports parked destinations to
// the hazard unit and requests a hold one slot before the FIFO fills.
// Optional feature macro: GPR_WB_BYPASS_EN (write an ALU result straight
// through when the port is idle and nothing is parked).
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BUF_DEPTH     = 2,
    parameter int unsigned NUM_TESTPORTS = 3
) (
    input logic              clk,
    input logic              reset_n,
    gpr_wb_arbiter_if.slave  bus_io
);

    localparam int unsigned CountW = count_width(BUF_DEPTH);
    localparam logic [CountW-1:0] HoldLvl = CountW'(BUF_DEPTH - 1);

    reg_index_t                     head_dest;
    logic       [DATA_WIDTH-1:0]    head_data;
    logic       [CountW-1:0]        count;
    logic                           fifo_full, fifo_empty;
    logic       [BUF_DEPTH-1:0]     entry_live;
    reg_index_t [BUF_DEPTH-1:0]     entry_dest;
    logic                           push, pop;

    logic                           wb_en;
    reg_index_t                     wb_dest;
    logic       [DATA_WIDTH-1:0]    wb_data;
    logic       [NUM_TESTPORTS-1:0] test_hit;

    reg_index_t                     last_dest_q, last_dest_d;
    logic       [DATA_WIDTH-1:0]    last_data_q, last_data_d;
    logic                           overflow_q, overflow_d;

    gpr_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .push_i       (push),
        .push_dest_i  (bus_io.alu_dest),
        .push_data_i  (bus_io.alu_data),
        .pop_i        (pop),
        .head_dest_o  (head_dest),
        .head_data_o  (head_data),
        .count_o      (count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .entry_live_o (entry_live),
        .entry_dest_o (entry_dest)
    );

    // Port arbitration: load > FIFO head > (optional) write-through ALU result.
    always_comb begin
        wb_en   = 1'b0;
        wb_dest = last_dest_q;
        wb_data = last_data_q;
        pop     = 1'b0;
        push    = bus_io.alu_valid;
        if (bus_io.mem_valid) begin
            wb_en   = 1'b1;
            wb_dest = bus_io.mem_dest;
            wb_data = bus_io.mem_data;
        end else if (!fifo_empty) begin
            wb_en   = 1'b1;
            wb_dest = head_dest;
            wb_data = head_data;
            pop     = 1'b1;
`ifdef GPR_WB_BYPASS_EN
        end else if (bus_io.alu_valid) begin
            wb_en   = 1'b1;
            wb_dest = bus_io.alu_dest;
            wb_data = bus_io.alu_data;
            push    = 1'b0;
`endif
        end
        // A push into a full FIFO with no pop is lost for good.
        overflow_d  = overflow_q | (push & fifo_full & ~pop);
        last_dest_d = wb_en ? wb_dest : last_dest_q;
        last_data_d = wb_en ? wb_data : last_data_q;
    end

    // Operand hazard lookup against entries still parked after this cycle.
    always_comb begin
        test_hit = '0;
        for (int i = 0; i < NUM_TESTPORTS; i++) begin
            for (int e = 0; e < BUF_DEPTH; e++) begin
                if (entry_live[e] && (entry_dest[e] == bus_io.test_idx[i])) begin
                    test_hit[i] = 1'b1;
                end
            end
        end
    end

    // Last written index/data (held while idle) and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_dest_q <= '0;
            last_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            last_dest_q <= last_dest_d;
            last_data_q <= last_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus_io.wb_en    = wb_en;
    assign bus_io.wb_dest  = wb_dest;
    assign bus_io.wb_data  = wb_data;
    // Registered count only, leaving one slot for the result already in flight.
    assign bus_io.hold     = (count >= HoldLvl);
    assign bus_io.test_hit = test_hit;
    assign bus_io.overflow = overflow_q;

endmodule
